// File: rtl/mips_seq_alu.sv
// Registered MIPS ALU with iterative multiply/divide into HI/LO.
// Single-cycle ops finish one edge after START; MULT/DIV hold BUSY while iterating.
module mips_seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [5:0]       OPCODE,
    input  logic [WIDTH-1:0] RS_VAL,
    input  logic [WIDTH-1:0] RT_VAL,
    input  logic [SHW-1:0]   SHAMT,
    input  logic [5:0]       FUNC,
    input  logic [15:0]      RAW_VAL,
    output logic [WIDTH-1:0] RESULT,
    output logic             SIG_B,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV_ZERO
);

    localparam int LUI_SH   = (WIDTH >= 16) ? WIDTH - 16 : 0;
    localparam int LUI_DROP = (WIDTH >= 16) ? 0 : 16 - WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               sig_b_q, sig_b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0]   sext, zext, lui_val;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_sig_b;

    assign sext    = WIDTH'($signed(RAW_VAL));
    assign zext    = WIDTH'(RAW_VAL);
    assign lui_val = WIDTH'(RAW_VAL >> LUI_DROP) << LUI_SH;

    // Iterative op decode: FUNC 0110xx, bit 0 = unsigned, bit 1 = divide
    logic               is_iter_op, op_signed, op_div, div_by_zero;
    logic [WIDTH-1:0]   rs_abs, rt_abs;

    assign is_iter_op  = (OPCODE == 6'b000000) && (FUNC[5:2] == 4'b0110);
    assign op_signed   = ~FUNC[0];
    assign op_div      = FUNC[1];
    assign div_by_zero = op_div && (RT_VAL == '0);
    assign rs_abs      = (op_signed && RS_VAL[WIDTH-1]) ? -RS_VAL : RS_VAL;
    assign rt_abs      = (op_signed && RT_VAL[WIDTH-1]) ? -RT_VAL : RT_VAL;

    // One shared iteration step; the first step runs straight from the operands at START
    logic               in_idle;
    logic [WIDTH-1:0]   it_hi, it_lo, it_b;
    logic               it_div;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_fits;
    logic [WIDTH-1:0]   nx_hi, nx_lo;

    assign in_idle   = (state_q == S_IDLE);
    assign it_hi     = in_idle ? '0 : acc_hi_q;
    assign it_lo     = in_idle ? (op_div ? rs_abs : rt_abs) : acc_lo_q;
    assign it_b      = in_idle ? (op_div ? rt_abs : rs_abs) : opb_q;
    assign it_div    = in_idle ? op_div : is_div_q;

    assign mul_sum   = {1'b0, it_hi} + (it_lo[0] ? {1'b0, it_b} : '0);
    assign div_shift = {it_hi, it_lo[WIDTH-1]};
    assign div_fits  = div_shift >= {1'b0, it_b};
    assign div_diff  = div_shift[WIDTH-1:0] - it_b;

    always_comb begin
        if (it_div) begin
            nx_hi = div_fits ? div_diff : div_shift[WIDTH-1:0];
            nx_lo = {it_lo[WIDTH-2:0], div_fits};
        end else begin
            {nx_hi, nx_lo} = {mul_sum, it_lo[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the magnitude result
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fin_hi, fin_lo;

    assign prod_fix = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    assign quo_fix  = neg_q ? -acc_lo_q : acc_lo_q;
    assign rem_fix  = rem_neg_q ? -acc_hi_q : acc_hi_q;
    assign fin_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign fin_lo   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];

    always_comb begin
        alu_res   = '0;
        alu_sig_b = 1'b0;
        case (OPCODE)
            6'b000000: begin
                case (FUNC)
                    6'b100000, 6'b100001: alu_res = RS_VAL + RT_VAL;
                    6'b100010, 6'b100011: alu_res = RS_VAL - RT_VAL;
                    6'b100100: alu_res = RS_VAL & RT_VAL;
                    6'b100101: alu_res = RS_VAL | RT_VAL;
                    6'b100110: alu_res = RS_VAL ^ RT_VAL;
                    6'b100111: alu_res = ~(RS_VAL | RT_VAL);
                    6'b101010: alu_res = {{(WIDTH-1){1'b0}}, $signed(RS_VAL) < $signed(RT_VAL)};
                    6'b101011: alu_res = {{(WIDTH-1){1'b0}}, RS_VAL < RT_VAL};
                    6'b000000: alu_res = RT_VAL << SHAMT;
                    6'b000010: alu_res = RT_VAL >> SHAMT;
                    6'b000011: alu_res = $signed(RT_VAL) >>> SHAMT;
                    6'b000100: alu_res = RT_VAL << RS_VAL[SHW-1:0];
                    6'b000110: alu_res = RT_VAL >> RS_VAL[SHW-1:0];
                    6'b000111: alu_res = $signed(RT_VAL) >>> RS_VAL[SHW-1:0];
                    6'b010000: alu_res = hi_q;
                    6'b010010: alu_res = lo_q;
                    default:   alu_res = '0;
                endcase
            end
            6'b001000, 6'b001001: alu_res = RS_VAL + sext;
            6'b001010: alu_res = {{(WIDTH-1){1'b0}}, $signed(RS_VAL) < $signed(sext)};
            6'b001011: alu_res = {{(WIDTH-1){1'b0}}, RS_VAL < sext};
            6'b001100: alu_res = RS_VAL & zext;
            6'b001101: alu_res = RS_VAL | zext;
            6'b001110: alu_res = RS_VAL ^ zext;
            6'b001111: alu_res = lui_val;
            6'b100011, 6'b101011: alu_res = RS_VAL + sext;
            6'b000100: begin
                alu_res   = RS_VAL - RT_VAL;
                alu_sig_b = (RS_VAL == RT_VAL);
            end
            6'b000101: begin
                alu_res   = RS_VAL - RT_VAL;
                alu_sig_b = (RS_VAL != RT_VAL);
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        sig_b_d    = sig_b_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opb_d      = opb_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (is_iter_op && div_by_zero) begin
                        hi_d       = RS_VAL;
                        lo_d       = '1;
                        result_d   = '1;
                        sig_b_d    = 1'b0;
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                    end else if (is_iter_op) begin
                        acc_hi_d  = nx_hi;
                        acc_lo_d  = nx_lo;
                        opb_d     = it_b;
                        is_div_d  = op_div;
                        neg_d     = op_signed && (RS_VAL[WIDTH-1] ^ RT_VAL[WIDTH-1]);
                        rem_neg_d = op_signed && RS_VAL[WIDTH-1];
                        cnt_d     = SHW'(1);
                        busy_d    = 1'b1;
                        state_d   = S_ITER;
                    end else begin
                        result_d = alu_res;
                        sig_b_d  = alu_sig_b;
                        done_d   = 1'b1;
                    end
                end
            end
            S_ITER: begin
                acc_hi_d = nx_hi;
                acc_lo_d = nx_lo;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                hi_d     = fin_hi;
                lo_d     = fin_lo;
                result_d = fin_lo;
                sig_b_d  = 1'b0;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            result_q   <= '0;
            sig_b_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opb_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            sig_b_q    <= sig_b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opb_q      <= opb_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            cnt_q      <= cnt_d;
        end
    end

    assign RESULT   = result_q;
    assign SIG_B    = sig_b_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign DIV_ZERO = div_zero_q;

endmodule

// File: doc/mips_seq_alu.md
Name: mips_seq_alu

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Executes the same R/I-type operations, plus iterative MULT/MULTU/DIV/DIVU into internal HI/LO registers, readable with MFHI/MFLO.
- Uses a START/BUSY/DONE handshake so the multi-cycle control unit can stall on long operations.
- Sits between the register-file read stage and the writeback/memory-address stage.

Parameters:
- WIDTH, 32: datapath width; must be a power of two, at least 8.
- SHW, $clog2(WIDTH): shift-amount width.

Ports:
- CLK  in  1  clock; rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request; sampled only in IDLE.
- OPCODE  in  6  MIPS opcode.
- RS_VAL  in  WIDTH  rs operand.
- RT_VAL  in  WIDTH  rt operand.
- SHAMT  in  SHW  shift amount.
- FUNC  in  6  R-type function field.
- RAW_VAL  in  16  raw immediate.
- RESULT  out  WIDTH  registered result.
- SIG_B  out  1  branch taken (BEQ/BNE only).
- BUSY  out  1  iterative operation in progress.
- DONE  out  1  one-cycle pulse: RESULT/SIG_B/HI/LO valid.
- DIV_ZERO  out  1  pulses with DONE when a DIV/DIVU divisor is 0.

Behaviour:
- Reset: RESULT=0, SIG_B=0, BUSY=0, DONE=0, DIV_ZERO=0, HI=0, LO=0, state=IDLE. RST mid-operation aborts the operation with no DONE.
- Immediates: SEXT = RAW_VAL sign-extended to WIDTH; ZEXT = RAW_VAL zero-extended.
- R-type (OPCODE 000000), by FUNC:
  - ADD/ADDU 100000/100001
  - SUB/SUBU 100010/100011
  - AND/OR/XOR/NOR 100100/100101/100110/100111
  - SLT 101010 (signed), SLTU 101011
  - SLL/SRL/SRA 000000/000010/000011 by SHAMT
  - SLLV/SRLV/SRAV 000100/000110/000111 by RS_VAL[SHW-1:0]
  - MFHI 010000, MFLO 010010
  - MULT/MULTU/DIV/DIVU 011000/011001/011010/011011
- I-type:
  - ADDI/ADDIU 001000/001001: RS+SEXT
  - SLTI/SLTIU 001010/001011: compare RS with SEXT (signed/unsigned)
  - ANDI/ORI/XORI 001100/001101/001110: use ZEXT
  - LUI 001111: RAW_VAL placed in the top 16 bits, lower bits 0
  - LW/SW 100011/101011: RS+SEXT
  - BEQ 000100: SIG_B = (RS==RT); RESULT = RS-RT
  - BNE 000101: SIG_B = (RS!=RT); RESULT = RS-RT
- Arithmetic: all add/sub wraps modulo 2^WIDTH; no overflow trap.
- Unknown OPCODE/FUNC: RESULT=0, SIG_B=0, DONE still pulses.
- SIG_B is 0 for every non-branch operation.
- FSM: IDLE -> (START & iterative op & divisor != 0) -> ITER -> FIN -> IDLE.
- Single-cycle ops: START sampled at edge t0 updates RESULT/SIG_B and asserts DONE for cycle t0..t1; latency 1.
- Iterative ops:
  - BUSY=1 from t0 through the edge that ends ITER.
  - ITER runs exactly WIDTH iterations: shift-add multiply, restoring divide.
  - FIN loads HI/LO, sets RESULT=LO and asserts DONE; BUSY drops at the same edge.
  - DONE therefore appears WIDTH+1 cycles after START.
- MULT/MULTU: {HI,LO} = full 2*WIDTH product (signed/unsigned).
- DIV/DIVU: LO = quotient, HI = remainder. Signed quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero: no iteration. At t0: HI=RS_VAL, LO=all ones, RESULT=LO, DONE=1, DIV_ZERO=1.
- START while BUSY is ignored and operands are not re-sampled. Operands are latched at t0, so input changes during ITER have no effect.
- MFHI/MFLO issued in the cycle DONE is high see the updated HI/LO.
- DONE and DIV_ZERO are never high for more than one consecutive cycle unless START is re-asserted.

Test Plan:
- Reset, then LW with RS=15, RAW=19 -> RESULT=34 and DONE=1 exactly one cycle after START; SIG_B=0, BUSY stays 0.
- LW with RS=23, RAW=16'hFFFC -> RESULT=19 (sign-extended immediate). ORI with RS=0, RAW=16'h8000 -> RESULT=32'h00008000.
- WIDTH=32, MULT RS=-3, RT=7 -> BUSY high 32 cycles, DONE at START+33, HI=FFFFFFFF, LO=FFFFFFEB. Then MFHI -> FFFFFFFF. START pulsed mid-ITER is ignored.
- DIV RS=-7, RT=2 -> LO=FFFFFFFD, HI=FFFFFFFF. DIVU RS=7, RT=0 -> DONE and DIV_ZERO at START+1, HI=7, LO=FFFFFFFF.
- BEQ RS=RT=5 -> SIG_B=1, RESULT=0. BNE with the same operands -> SIG_B=0.
- Assert RST 10 cycles into a MULT -> next cycle all outputs 0, no DONE, HI/LO=0; the next ADD (1+2) -> RESULT=3 one cycle later.
